// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. a 2-entry aux result FIFO,
// with a pending-write scoreboard. Define WB_STARVE_GUARD_EN to build the starvation guard.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_write,
  input  logic [2:0]  pipe_num,
  input  logic [15:0] pipe_data,
  input  logic        aux_issue,
  input  logic [2:0]  aux_issue_num,
  input  logic        aux_valid,
  input  logic [2:0]  aux_num,
  input  logic [15:0] aux_data,
  output logic        aux_ready,
  output logic [7:0]  busy,
  output logic        stall_pipe,
  output logic        wr_en,
  output logic [2:0]  wr_num,
  output logic [15:0] wr_data
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..7");
  end

  // Slot 0 is the FIFO head; r_vld[1] implies r_vld[0].
  logic [1:0]  r_vld;
  logic [2:0]  r_num  [2];
  logic [15:0] r_data [2];
  logic [7:0]  r_busy;
  logic        r_wr_en;
  logic [2:0]  r_wr_num;
  logic [15:0] r_wr_data;

  logic        w_pop, w_push, w_k0, w_k1, w_keep0, w_keep1;
  logic [1:0]  w_vld;
  logic [2:0]  w_num  [2];
  logic [15:0] w_data [2];
  logic [7:0]  w_clr, w_set;

  assign aux_ready = ~r_vld[1];
  assign busy      = r_busy;
  assign wr_en     = r_wr_en;
  assign wr_num    = r_wr_num;
  assign wr_data   = r_wr_data;

  always_comb begin
    w_pop   = ~pipe_write & r_vld[0];
    w_push  = aux_valid & aux_ready;
    w_k0    = pipe_write & r_vld[0] & (r_num[0] == pipe_num);
    w_k1    = pipe_write & r_vld[1] & (r_num[1] == pipe_num);
    w_keep0 = r_vld[0] & ~w_k0 & ~w_pop;
    w_keep1 = r_vld[1] & ~w_k1;

    w_clr = '0;
    if (w_pop || w_k0) w_clr[r_num[0]] = 1'b1;
    if (w_k1)          w_clr[r_num[1]] = 1'b1;
    w_set = '0;
    if (aux_issue) w_set[aux_issue_num] = 1'b1;

    // Compact survivors toward the head, then append the incoming entry.
    w_vld     = '0;
    w_num[0]  = r_num[0];
    w_num[1]  = r_num[1];
    w_data[0] = r_data[0];
    w_data[1] = r_data[1];
    if (w_keep0) begin
      w_vld[0] = 1'b1;
      w_vld[1] = w_keep1;
    end else if (w_keep1) begin
      w_vld[0]  = 1'b1;
      w_num[0]  = r_num[1];
      w_data[0] = r_data[1];
    end
    if (w_push) begin
      if (!w_vld[0]) begin
        w_vld[0]  = 1'b1;
        w_num[0]  = aux_num;
        w_data[0] = aux_data;
      end else begin
        w_vld[1]  = 1'b1;
        w_num[1]  = aux_num;
        w_data[1] = aux_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld     <= '0;
      r_busy    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_num  <= '0;
      r_wr_data <= '0;
    end else begin
      r_vld     <= w_vld;
      r_num[0]  <= w_num[0];
      r_num[1]  <= w_num[1];
      r_data[0] <= w_data[0];
      r_data[1] <= w_data[1];
      r_busy    <= (r_busy & ~w_clr) | w_set;
      if (pipe_write) begin
        r_wr_en   <= 1'b1;
        r_wr_num  <= pipe_num;
        r_wr_data <= pipe_data;
      end else if (w_pop) begin
        r_wr_en   <= 1'b1;
        r_wr_num  <= r_num[0];
        r_wr_data <= r_data[0];
      end else begin
        r_wr_en <= 1'b0;
      end
    end
  end

`ifdef WB_STARVE_GUARD_EN
  logic [2:0] r_starve;
  logic       r_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_stall <= 1'b0;
      if (r_vld[0] && pipe_write) begin
        if (r_starve == 3'(STARVE_LIMIT - 1)) begin
          r_starve <= '0;
          r_stall  <= 1'b1;
        end else begin
          r_starve <= r_starve + 3'd1;
        end
      end else begin
        r_starve <= '0;
      end
    end
  end

  assign stall_pipe = r_stall;
`else
  assign stall_pipe = 1'b0;
`endif

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback and a multi-cycle auxiliary unit (LDR-miss/multiply results that return out of band). It sits between the writeback stage and the register file, buffers auxiliary results in a 2-entry FIFO, and keeps a per-register scoreboard so decode can stall on pending auxiliary writes. Pipeline writes always win; an optional starvation guard forces a pipeline bubble so auxiliary results cannot wait forever.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive cycles a non-empty FIFO may be denied before a bubble is requested (1..7).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- pipe_write  in  1  pipeline writeback request this cycle
- pipe_num  in  3  pipeline destination register
- pipe_data  in  16  pipeline writeback data
- aux_issue  in  1  decode issued an aux-unit op this cycle
- aux_issue_num  in  3  destination of the issued aux op
- aux_valid  in  1  aux result available
- aux_num  in  3  aux result destination
- aux_data  in  16  aux result data
- aux_ready  out  1  FIFO can accept (= not full)
- busy  out  8  bit n set: aux write to register n pending
- stall_pipe  out  1  request one pipeline bubble (starvation guard)
- wr_en  out  1  register-file write enable
- wr_num  out  3  register-file write index
- wr_data  out  16  register-file write data

## Operation
- Aux handshake: transfer when aux_valid && aux_ready; entry {num,data} pushed at that edge. aux_ready is combinational from FIFO count only (count<2).
- Port select per cycle t: if pipe_write, the pipeline is granted; else if FIFO non-empty, the head is popped and granted; else idle.
- Granted write is registered: wr_en/wr_num/wr_data valid in cycle t+1. Push and pop in the same cycle are allowed when count is 1 or 2 (count is unchanged); a push into an empty FIFO is never popped in the same cycle (no bypass).
- Kill rule: a granted pipeline write to register n invalidates every FIFO entry with num n (the pipeline write is younger); killed entries are dropped without a port write, and their busy bit is cleared.
- Scoreboard: aux_issue sets busy[aux_issue_num] at the edge; a granted or killed aux entry for n clears busy[n]. Same-edge set and clear of the same bit: the set wins.
- Starvation counter: increments each cycle the FIFO is non-empty and pipe_write is high; resets to 0 on any pop or when the FIFO is empty. When it reaches STARVE_LIMIT, stall_pipe is high for exactly one cycle and the counter resets to 0; the pipeline presents pipe_write=0 in the following cycle.
- Reset: FIFO emptied, busy=0, counter=0, wr_en=0, wr_num=0, wr_data=0, stall_pipe=0; aux_ready=1 in the first cycle after reset. Reset mid-operation discards all buffered entries.

## Timing
- Pipeline write latency: 1 cycle (request at t, wr_en at t+1).
- Aux latency, empty FIFO and no pipeline traffic: push at t, pop at t+1, wr_en at t+2.
- FIFO order is strict FIFO; at most one port write per cycle.
- stall_pipe is registered; it asserts in the cycle after the counter reaches STARVE_LIMIT.
- busy reflects the edge updates in the following cycle; no combinational path from aux_issue to busy.

## Configuration
- WB_STARVE_GUARD_EN defined: the starvation counter and stall_pipe logic are built as above.
- Not defined: the counter is removed and stall_pipe is tied to 0; aux entries drain only in cycles without pipeline writes.

## Test plan
- Reset, then pipe_write=1, pipe_num=3, pipe_data=16'hBEEF at t -> wr_en=1, wr_num=3, wr_data=16'hBEEF at t+1; all outputs 0 and aux_ready=1 immediately after reset.
- aux_issue num=5, then aux_valid num=5 data=16'h1234 with no pipeline traffic -> busy[5]=1; wr_en with num 5 data 16'h1234 two cycles after the push; busy[5]=0 after the pop.
- Push two aux entries while pipe_write is held high -> aux_ready=0 after the second push; a third aux_valid is not accepted; entries drain in order once pipe_write drops.
- With WB_STARVE_GUARD_EN and STARVE_LIMIT=4, FIFO non-empty and pipe_write held high -> stall_pipe pulses once after 4 denied cycles; a pop follows when pipe_write=0.
- FIFO holds an entry for r2, pipeline writes r2 -> wr_num=2 with pipeline data, the FIFO entry is dropped, busy[2]=0, and there is no later write to r2.
- Assert rst with 2 entries buffered -> no further wr_en; busy=0, aux_ready=1.
